nist_run_sequencer: RTL and testbench

//  Sequences repeated runs of the NIST SP800-22 frequency test engine (monobit + block).
//  - Splits the raw RNG bit stream into SEQ_LEN-bit sequences.
//  - Clears the engine before each run and forwards exactly SEQ_LEN bits to it.
//  - Collects the engine's active-low per-run results and tallies passes over N_RUNS runs.
//  - Reports a final verdict. Sits between the RNG input pin and the test engine in the top level.

---
 rtl/nist_run_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_nist_run_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/nist_run_sequencer.sv
// -----------------------------------------------------------------------------
// nist_run_sequencer
//
// Runs a campaign of N_RUNS back-to-back frequency-test runs on the NIST
// SP800-22 engine. For each run it clears the engine and forwards exactly
// SEQ_LEN accepted RNG bits, marking the final one with eng_last. It then
// waits up to TIMEOUT cycles for the engine's result strobe and tallies the
// active-low monobit/block results. After N_RUNS runs it reports a
// two-bit verdict.
//
// Ports
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   start                 campaign request (honoured only when not busy)
//   rnd_in, rnd_valid     raw RNG bit and its valid strobe
//   eng_npass1/2          engine results (active low), valid with eng_done
//   eng_done              engine result strobe
//   eng_clr               one-cycle engine clear at the start of each run
//   eng_bit/_vld/_last    bit stream towards the engine
//   busy, done, err       campaign status levels
//   pass_cnt1/2, run_cnt  running tallies
//   verdict               {block ok, monobit ok}, valid while done
// -----------------------------------------------------------------------------
module nist_run_sequencer #(
    parameter int SEQ_LEN  = 128,
    parameter int N_RUNS   = 8,
    parameter int MIN_PASS = 7,
    parameter int TIMEOUT  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        rnd_in,
    input  logic                        rnd_valid,
    input  logic                        eng_npass1,
    input  logic                        eng_npass2,
    input  logic                        eng_done,
    output logic                        eng_clr,
    output logic                        eng_bit,
    output logic                        eng_bit_vld,
    output logic                        eng_last,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [$clog2(N_RUNS+1)-1:0] pass_cnt1,
    output logic [$clog2(N_RUNS+1)-1:0] pass_cnt2,
    output logic [$clog2(N_RUNS+1)-1:0] run_cnt,
    output logic [1:0]                  verdict
);

    localparam int CW = $clog2(N_RUNS + 1);
    localparam int BW = $clog2(SEQ_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_TALLY = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t          state_r, state_s;
    logic [BW-1:0]   bit_cnt_r, bit_cnt_s;
    logic [TW-1:0]   timer_r, timer_s;
    logic            np1_r, np1_s;
    logic            np2_r, np2_s;
    logic [CW-1:0]   run_cnt_s, pass1_s, pass2_s;
    logic [1:0]      verdict_s;
    logic            bit_s, vld_s, last_s;

    // Next-state, counter and bit-path decode for the campaign sequencer.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        timer_s   = timer_r;
        np1_s     = np1_r;
        np2_s     = np2_r;
        run_cnt_s = run_cnt;
        pass1_s   = pass_cnt1;
        pass2_s   = pass_cnt2;
        verdict_s = verdict;
        bit_s     = eng_bit;
        vld_s     = 1'b0;
        last_s    = 1'b0;

        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_s   = S_CLEAR;
                    run_cnt_s = {CW{1'b0}};
                    pass1_s   = {CW{1'b0}};
                    pass2_s   = {CW{1'b0}};
                    verdict_s = 2'b00;
                end else begin
                    state_s = state_r;
                end
            end
            S_CLEAR: begin
                bit_cnt_s = {BW{1'b0}};
                state_s   = S_FEED;
            end
            S_FEED: begin
                if (rnd_valid) begin
                    vld_s = 1'b1;
                    bit_s = rnd_in;
                    if (bit_cnt_r == BW'(SEQ_LEN - 1)) begin
                        last_s    = 1'b1;
                        bit_cnt_s = {BW{1'b0}};
                        timer_s   = {TW{1'b0}};
                        state_s   = S_WAIT;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BW'(1);
                    end
                end else begin
                    vld_s = 1'b0;
                end
            end
            S_WAIT: begin
                // A strobe on the final timer cycle still wins over the timeout.
                if (eng_done) begin
                    np1_s   = eng_npass1;
                    np2_s   = eng_npass2;
                    state_s = S_TALLY;
                end else if (timer_r == TW'(TIMEOUT - 1)) begin
                    state_s = S_ERR;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            S_TALLY: begin
                if (run_cnt < CW'(N_RUNS)) begin
                    run_cnt_s = run_cnt + CW'(1);
                end else begin
                    run_cnt_s = run_cnt;
                end
                if (!np1_r && (pass_cnt1 < CW'(N_RUNS))) begin
                    pass1_s = pass_cnt1 + CW'(1);
                end else begin
                    pass1_s = pass_cnt1;
                end
                if (!np2_r && (pass_cnt2 < CW'(N_RUNS))) begin
                    pass2_s = pass_cnt2 + CW'(1);
                end else begin
                    pass2_s = pass_cnt2;
                end
                if (run_cnt_s == CW'(N_RUNS)) begin
                    state_s   = S_DONE;
                    verdict_s = {(pass2_s >= CW'(MIN_PASS)), (pass1_s >= CW'(MIN_PASS))};
                end else begin
                    state_s = S_CLEAR;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, counters and all outputs registered; status outputs follow the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            bit_cnt_r   <= {BW{1'b0}};
            timer_r     <= {TW{1'b0}};
            np1_r       <= 1'b0;
            np2_r       <= 1'b0;
            run_cnt     <= {CW{1'b0}};
            pass_cnt1   <= {CW{1'b0}};
            pass_cnt2   <= {CW{1'b0}};
            verdict     <= 2'b00;
            eng_clr     <= 1'b0;
            eng_bit     <= 1'b0;
            eng_bit_vld <= 1'b0;
            eng_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_r     <= state_s;
            bit_cnt_r   <= bit_cnt_s;
            timer_r     <= timer_s;
            np1_r       <= np1_s;
            np2_r       <= np2_s;
            run_cnt     <= run_cnt_s;
            pass_cnt1   <= pass1_s;
            pass_cnt2   <= pass2_s;
            verdict     <= verdict_s;
            eng_clr     <= (state_s == S_CLEAR);
            eng_bit     <= bit_s;
            eng_bit_vld <= vld_s;
            eng_last    <= last_s;
            busy        <= (state_s == S_CLEAR) || (state_s == S_FEED) ||
                           (state_s == S_WAIT)  || (state_s == S_TALLY);
            done        <= (state_s == S_DONE);
            err         <= (state_s == S_ERR);
        end
    end

endmodule

// File: tb/tb_nist_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nist_run_sequencer
//
// Campaign-level bench: each campaign is scripted as the timeline the
// sequencer must follow (clear, SEQ_LEN accepted bits, engine response,
// tally). Expected bits, run and pass counts, and verdicts come from the
// stimulus the bench itself chose.
// -----------------------------------------------------------------------------
module tb_nist_run_sequencer;

    localparam int SEQ_LEN  = 128;
    localparam int N_RUNS   = 8;
    localparam int MIN_PASS = 7;
    localparam int TIMEOUT  = 16;
    localparam int CW       = $clog2(N_RUNS + 1);

    logic          clk = 1'b0;
    logic          rst_n, start, rnd_in, rnd_valid;
    logic          eng_npass1, eng_npass2, eng_done;
    logic          eng_clr, eng_bit, eng_bit_vld, eng_last;
    logic          busy, done, err;
    logic [CW-1:0] pass_cnt1, pass_cnt2, run_cnt;
    logic [1:0]    verdict;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    nist_run_sequencer #(
        .SEQ_LEN(SEQ_LEN), .N_RUNS(N_RUNS), .MIN_PASS(MIN_PASS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rnd_in(rnd_in), .rnd_valid(rnd_valid),
        .eng_npass1(eng_npass1), .eng_npass2(eng_npass2), .eng_done(eng_done),
        .eng_clr(eng_clr), .eng_bit(eng_bit), .eng_bit_vld(eng_bit_vld), .eng_last(eng_last),
        .busy(busy), .done(done), .err(err),
        .pass_cnt1(pass_cnt1), .pass_cnt2(pass_cnt2), .run_cnt(run_cnt), .verdict(verdict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One full campaign. mode: 0 rnd_valid always high, 1 toggling, 2 random
    // (with stray eng_done/start pulses while feeding). tmo_run / abort_run
    // select a run that times out / is reset mid-feed (-1 for none).
    task automatic campaign(input logic [7:0] m1, input logic [7:0] m2, input int mode,
                            input int tmo_run, input int abort_run, input bit min_lat);
        int  p1, p2, k, d, t_start;
        bit  v, b, tog;
        p1 = 0;
        p2 = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        t_start = cyc;
        for (int r = 0; r < N_RUNS; r++) begin
            check("clr_pulse", eng_clr, 1);
            check("busy_clear", busy, 1);
            check("done_low", done, 0);
            check("err_low", err, 0);
            check("run_cnt_start", run_cnt, r);
            check("p1_start", pass_cnt1, p1);
            check("p2_start", pass_cnt2, p2);
            rnd_valid = 1'b1;
            rnd_in = 1'($urandom);
            tick();
            check("clr_one_cycle", eng_clr, 0);
            check("vld_dropped_clear", eng_bit_vld, 0);
            k = 0;
            tog = 1'b1;
            while (k < SEQ_LEN) begin
                case (mode)
                    0: v = 1'b1;
                    1: begin v = tog; tog = !tog; end
                    default: v = ($urandom % 4) != 0;
                endcase
                b = 1'($urandom);
                rnd_valid = v;
                rnd_in = b;
                if (mode == 2) begin
                    eng_done = ($urandom % 16) == 0;
                    eng_npass1 = 1'($urandom);
                    eng_npass2 = 1'($urandom);
                    start = ($urandom % 8) == 0;
                end
                tick();
                check("bit_vld", eng_bit_vld, v);
                check("busy_feed", busy, 1);
                check("clr_feed", eng_clr, 0);
                if (v) begin
                    check("bit_val", eng_bit, b);
                    check("bit_last", eng_last, (k == SEQ_LEN - 1));
                    k++;
                end else begin
                    check("last_idle", eng_last, 0);
                end
                if (r == abort_run && k == 10) begin
                    rst_n = 1'b0;
                    start = 1'b0;
                    eng_done = 1'b0;
                    rnd_valid = 1'b1;
                    tick();
                    check("abort_vld", eng_bit_vld, 0);
                    check("abort_clr", eng_clr, 0);
                    check("abort_busy", busy, 0);
                    check("abort_run_cnt", run_cnt, 0);
                    check("abort_p1", pass_cnt1, 0);
                    check("abort_p2", pass_cnt2, 0);
                    rst_n = 1'b1;
                    rnd_valid = 1'b0;
                    tick();
                    check("abort_idle_busy", busy, 0);
                    check("abort_idle_clr", eng_clr, 0);
                    return;
                end
            end
            start = 1'b0;
            eng_done = 1'b0;
            if (r == tmo_run) begin
                for (int i = 0; i < TIMEOUT; i++) begin
                    rnd_valid = 1'($urandom);
                    tick();
                    check("tmo_err", err, (i == TIMEOUT - 1));
                    check("tmo_busy", busy, (i != TIMEOUT - 1));
                    check("tmo_vld", eng_bit_vld, 0);
                end
                rnd_valid = 1'b1;
                eng_done = 1'b1;
                tick();
                tick();
                eng_done = 1'b0;
                check("err_hold", err, 1);
                check("err_run_cnt", run_cnt, r);
                check("err_p1", pass_cnt1, p1);
                check("err_p2", pass_cnt2, p2);
                check("err_no_bits", eng_bit_vld, 0);
                return;
            end
            d = min_lat ? 0 : int'($urandom_range(0, TIMEOUT - 1));
            for (int i = 0; i < d; i++) begin
                rnd_valid = 1'($urandom);
                tick();
                check("wait_vld", eng_bit_vld, 0);
                check("wait_err", err, 0);
                check("wait_busy", busy, 1);
            end
            eng_done = 1'b1;
            eng_npass1 = m1[r];
            eng_npass2 = m2[r];
            tick();
            eng_done = 1'b0;
            eng_npass1 = 1'($urandom);
            eng_npass2 = 1'($urandom);
            check("tally_busy", busy, 1);
            check("tally_run_cnt", run_cnt, r);
            if (!m1[r]) p1++;
            if (!m2[r]) p2++;
            tick();
            check("run_cnt", run_cnt, r + 1);
            check("pass_cnt1", pass_cnt1, p1);
            check("pass_cnt2", pass_cnt2, p2);
        end
        check("done", done, 1);
        check("busy_done", busy, 0);
        check("err_done", err, 0);
        check("verdict", verdict, {(p2 >= MIN_PASS), (p1 >= MIN_PASS)});
        if (min_lat) check("latency", cyc - t_start, N_RUNS * (SEQ_LEN + 3));
        rnd_valid = 1'b1;
        eng_done = 1'b1;
        tick();
        tick();
        eng_done = 1'b0;
        check("done_hold", done, 1);
        check("verdict_hold", verdict, {(p2 >= MIN_PASS), (p1 >= MIN_PASS)});
        check("run_cnt_hold", run_cnt, N_RUNS);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        rnd_in = 1'b1;
        rnd_valid = 1'b1;
        eng_npass1 = 1'b0;
        eng_npass2 = 1'b0;
        eng_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_outs", {eng_clr, eng_bit, eng_bit_vld, eng_last, busy, done, err}, 0);
            check("rst_cnts", {pass_cnt1, pass_cnt2, run_cnt, verdict}, 0);
        end
        eng_done = 1'b0;
        rst_n = 1'b1;
        // start is still held: first edge out of reset must launch the clear.
        campaign(8'h00, 8'h00, 0, -1, -1, 1'b1);
        campaign(8'b0010_0001, 8'b0000_1000, 2, -1, -1, 1'b0);
        check("verdict_mixed", verdict, 2'b10);
        campaign(8'($urandom), 8'($urandom), 1, -1, -1, 1'b0);
        campaign(8'($urandom), 8'($urandom), 2, 2, -1, 1'b0);
        campaign(8'($urandom), 8'($urandom), 2, -1, -1, 1'b0);
        campaign(8'h00, 8'h00, 2, -1, 4, 1'b0);
        campaign(8'($urandom), 8'($urandom), 2, -1, -1, 1'b0);
        campaign(8'hFF, 8'h7F, 0, -1, -1, 1'b1);
        check("verdict_none", verdict, 2'b00);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
